// File: rtl/bcd_count_ctrl_if.sv
// Command handshake bundle for bcd_count_ctrl: requester drives valid/dir/target,
// the controller answers with ready.
interface bcd_count_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_target;

  modport master (output cmd_valid, cmd_dir, cmd_target, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_dir, cmd_target, output cmd_ready);
endinterface

// File: rtl/bcd_count_ctrl.sv
// Steps an external up/down BCD counter until it shows a commanded digit.
// Optional BCD_CTRL_TIMEOUT_EN: abort to ERR after 10 enabled steps without a match.
module bcd_count_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  bcd_count_ctrl_if.slave        cmd,
  input  logic                   abort,
  input  logic [3:0]             cnt_val,
  output logic                   cnt_en,
  output logic                   cnt_x,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [3:0]             steps
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t     state, state_nxt;
  logic [3:0] tgt;
  logic       dir;
  logic       hit;
  logic       accept;

  assign hit    = (cnt_val == tgt);
  assign accept = (state == IDLE) && cmd.cmd_valid;

  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    cnt_en        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    cnt_x         = dir;
    unique case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (cmd.cmd_valid)
          state_nxt = (cmd.cmd_target > 4'd9 || cnt_val > 4'd9) ? ERR : RUN;
      end
      RUN: begin
        // Enable is purely combinational so abort and reset cut it in the same cycle.
        cnt_en = !hit && !abort;
        if (abort)
          state_nxt = IDLE;
        else if (hit)
          state_nxt = DONE;
`ifdef BCD_CTRL_TIMEOUT_EN
        else if (cnt_en && steps == 4'd9)
          state_nxt = ERR;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tgt   <= 4'd0;
      dir   <= 1'b0;
      steps <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tgt   <= cmd.cmd_target;
        dir   <= cmd.cmd_dir;
        steps <= 4'd0;
      end else if (cnt_en && steps != 4'hF) begin
        steps <= steps + 4'd1;
      end
    end
  end

endmodule
